// File: rtl/mostra_sequencia.sv
// mostra_sequencia: flashes memory positions 0..rodada on the LEDs, each lit for
// T_ACESO cycles then dark for T_APAGADO cycles, and pulses pronto when done.
module mostra_sequencia #(
  parameter int T_ACESO   = 500,
  parameter int T_APAGADO = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       abortar,
  input  logic [3:0] rodada,
  input  logic [3:0] dado,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado,
  output logic [3:0] db_indice
);
  localparam int T_MAX = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [TW-1:0] ACESO_FIM   = TW'(T_ACESO - 1);
  localparam logic [TW-1:0] APAGADO_FIM = TW'(T_APAGADO - 1);
  typedef enum logic [3:0] {
    OCIOSO   = 4'd0,
    ENDERECA = 4'd1,
    ACESO    = 4'd2,
    APAGADO  = 4'd3,
    PROXIMO  = 4'd4,
    FIM      = 4'd5
  } estado_t;
  estado_t       estado_q, estado_d;
  logic [3:0]    indice_q, indice_d;
  logic [3:0]    rodada_q, rodada_d;
  logic [TW-1:0] timer_q, timer_d;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      indice_q <= '0;
      rodada_q <= '0;
      timer_q  <= '0;
    end else begin
      estado_q <= estado_d;
      indice_q <= indice_d;
      rodada_q <= rodada_d;
      timer_q  <= timer_d;
    end
  end
  always_comb begin
    estado_d = estado_q;
    indice_d = indice_q;
    rodada_d = rodada_q;
    timer_d  = timer_q;
    if (abortar) begin
      // abort also suppresses a simultaneous start while idle
      if (estado_q != OCIOSO) begin
        estado_d = OCIOSO;
        indice_d = '0;
        timer_d  = '0;
      end
    end else begin
      case (estado_q)
        OCIOSO: if (iniciar) begin
          rodada_d = rodada;
          indice_d = '0;
          timer_d  = '0;
          estado_d = ENDERECA;
        end
        ENDERECA: begin
          timer_d  = '0;
          estado_d = ACESO;
        end
        ACESO: begin
          timer_d  = (timer_q == ACESO_FIM) ? '0 : timer_q + 1'b1;
          estado_d = (timer_q == ACESO_FIM) ? APAGADO : ACESO;
        end
        APAGADO: begin
          timer_d  = (timer_q == APAGADO_FIM) ? '0 : timer_q + 1'b1;
          estado_d = (timer_q == APAGADO_FIM) ? PROXIMO : APAGADO;
        end
        // compare before incrementing so rodada=15 never wraps the index
        PROXIMO: begin
          estado_d = (indice_q == rodada_q) ? FIM : ENDERECA;
          indice_d = (indice_q == rodada_q) ? indice_q : indice_q + 4'd1;
        end
        FIM: estado_d = OCIOSO;
        default: begin
          estado_d = OCIOSO;
          indice_d = '0;
          timer_d  = '0;
        end
      endcase
    end
  end
  assign endereco  = indice_q;
  assign db_indice = indice_q;
  assign leds      = (estado_q == ACESO) ? dado : 4'd0;
  assign ocupado   = (estado_q != OCIOSO);
  assign pronto    = (estado_q == FIM);
  assign db_estado = estado_q;
endmodule

// File: tb/tb_mostra_sequencia.sv
// tb_mostra_sequencia: directed checks of the LED sequence presenter with a synchronous ROM model.
module tb_mostra_sequencia;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic iniciar = 1'b0, abortar = 1'b0;
  logic [3:0] rodada = '0, dado0;
  logic [3:0] end0, leds0, est0, ind0;
  logic oc0, pr0;
  logic ini1 = 1'b0, ab1 = 1'b0;
  logic [3:0] rod1 = '0, dado1;
  logic [3:0] end1, leds1, est1, ind1;
  logic oc1, pr1;
  logic [3:0] mem0 [16];
  logic [3:0] mem1 [16];
  int n_chk = 0, n_fail = 0;
  always #5 clock = ~clock;
  mostra_sequencia #(.T_ACESO(3), .T_APAGADO(2)) u_dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .abortar(abortar), .rodada(rodada),
    .dado(dado0), .endereco(end0), .leds(leds0), .ocupado(oc0), .pronto(pr0),
    .db_estado(est0), .db_indice(ind0));
  mostra_sequencia #(.T_ACESO(1), .T_APAGADO(1)) u_dut1 (
    .clock(clock), .reset(reset), .iniciar(ini1), .abortar(ab1), .rodada(rod1),
    .dado(dado1), .endereco(end1), .leds(leds1), .ocupado(oc1), .pronto(pr1),
    .db_estado(est1), .db_indice(ind1));
  always_ff @(posedge clock) begin
    dado0 <= mem0[end0];
    dado1 <= mem1[end1];
  end
  typedef struct packed {
    logic [3:0] leds;
    logic       oc;
    logic       pr;
    logic [3:0] ende;
    logic [3:0] est;
  } exp_t;
  typedef struct {
    logic ini;
    exp_t e;
  } vec_t;
  vec_t tab [10];
  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s c%0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask
  // expected outputs at cycle c after the start edge, from the per-element period formula
  function automatic exp_t model(input int ta, input int tb, input int r, input int c,
                                 input int ab_c, input logic [3:0] val_k);
    int p, last, k, ph;
    exp_t e;
    p = ta + tb + 2;
    last = (r + 1) * p;
    k = c / p;
    ph = c % p;
    e = '0;
    if (ab_c >= 0 && c > ab_c) return e;
    if (c > last) begin
      e.ende = 4'(r);
      return e;
    end
    e.oc = 1'b1;
    if (c == last) begin
      e.pr = 1'b1;
      e.ende = 4'(r);
      e.est = 4'd5;
      return e;
    end
    e.ende = 4'(k);
    e.est = (ph == 0) ? 4'd1 : (ph <= ta) ? 4'd2 : (ph <= ta + tb) ? 4'd3 : 4'd4;
    e.leds = (e.est == 4'd2) ? val_k : 4'd0;
    return e;
  endfunction
  task automatic run0(input int r, input int ab_c, input int chg_c, input int rep_c, input string nm);
    int last, np, kk;
    exp_t e;
    last = (r + 1) * 7;
    np = 0;
    @(negedge clock);
    rodada = 4'(r);
    iniciar = 1'b1;
    for (int c = 0; c <= last + 2; c++) begin
      @(negedge clock);
      kk = c / 7;
      e = model(3, 2, r, c, ab_c, (kk > 15) ? 4'd0 : mem0[kk]);
      chk({nm, ".leds"}, c, 32'(leds0), 32'(e.leds));
      chk({nm, ".ocupado"}, c, 32'(oc0), 32'(e.oc));
      chk({nm, ".pronto"}, c, 32'(pr0), 32'(e.pr));
      chk({nm, ".endereco"}, c, 32'(end0), 32'(e.ende));
      chk({nm, ".db_indice"}, c, 32'(ind0), 32'(e.ende));
      chk({nm, ".db_estado"}, c, 32'(est0), 32'(e.est));
      np += int'(pr0);
      iniciar = (c == rep_c);
      abortar = (c == ab_c);
      if (c == chg_c) rodada = 4'd0;
    end
    chk({nm, ".pronto_count"}, last, 32'(np), (ab_c >= 0) ? 32'd0 : 32'd1);
  endtask
  initial begin
    int lit, np, kk;
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      mem0[i] = 4'(i);
      mem1[i] = 4'(i) ^ 4'h5;
    end
    mem0[0] = 4'd1; mem0[1] = 4'd2; mem0[2] = 4'd4; mem0[3] = 4'd8;
    tab[0] = '{1'b1, '{4'd0, 1'b0, 1'b0, 4'd0, 4'd0}};
    tab[1] = '{1'b0, '{4'd0, 1'b1, 1'b0, 4'd0, 4'd1}};
    tab[2] = '{1'b0, '{4'd1, 1'b1, 1'b0, 4'd0, 4'd2}};
    tab[3] = '{1'b0, '{4'd1, 1'b1, 1'b0, 4'd0, 4'd2}};
    tab[4] = '{1'b0, '{4'd1, 1'b1, 1'b0, 4'd0, 4'd2}};
    tab[5] = '{1'b0, '{4'd0, 1'b1, 1'b0, 4'd0, 4'd3}};
    tab[6] = '{1'b0, '{4'd0, 1'b1, 1'b0, 4'd0, 4'd3}};
    tab[7] = '{1'b0, '{4'd0, 1'b1, 1'b0, 4'd0, 4'd4}};
    tab[8] = '{1'b0, '{4'd0, 1'b1, 1'b1, 4'd0, 4'd5}};
    tab[9] = '{1'b0, '{4'd0, 1'b0, 1'b0, 4'd0, 4'd0}};
    #12;
    chk("rst.leds", 0, 32'(leds0), 32'd0);
    chk("rst.ocupado", 0, 32'(oc0), 32'd0);
    chk("rst.pronto", 0, 32'(pr0), 32'd0);
    chk("rst.db_estado", 0, 32'(est0), 32'd0);
    chk("rst.endereco", 0, 32'(end0), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    // reset in the middle of the second element's lit phase
    @(negedge clock);
    rodada = 4'd1;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    repeat (8) @(negedge clock);
    chk("midrst.leds_before", 8, 32'(leds0), 32'd2);
    chk("midrst.ocupado_before", 8, 32'(oc0), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst.leds", 8, 32'(leds0), 32'd0);
    chk("midrst.ocupado", 8, 32'(oc0), 32'd0);
    chk("midrst.db_estado", 8, 32'(est0), 32'd0);
    chk("midrst.pronto", 8, 32'(pr0), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    rodada = 4'd0;
    for (int s = 0; s < 10; s++) begin
      @(negedge clock);
      chk("tab.leds", s - 1, 32'(leds0), 32'(tab[s].e.leds));
      chk("tab.ocupado", s - 1, 32'(oc0), 32'(tab[s].e.oc));
      chk("tab.pronto", s - 1, 32'(pr0), 32'(tab[s].e.pr));
      chk("tab.endereco", s - 1, 32'(end0), 32'(tab[s].e.ende));
      chk("tab.db_estado", s - 1, 32'(est0), 32'(tab[s].e.est));
      iniciar = tab[s].ini;
    end
    run0(2, -1, -1, -1, "r2");
    run0(2, -1, 5, 9, "r2_ignore");
    run0(3, 9, -1, -1, "abort");
    run0(0, -1, -1, -1, "restart");
    @(negedge clock);
    iniciar = 1'b1;
    abortar = 1'b1;
    @(negedge clock);
    chk("abort_idle.ocupado", 0, 32'(oc0), 32'd0);
    chk("abort_idle.db_estado", 0, 32'(est0), 32'd0);
    iniciar = 1'b0;
    abortar = 1'b0;
    @(negedge clock);
    rod1 = 4'd15;
    ini1 = 1'b1;
    lit = 0;
    np = 0;
    for (int c = 0; c <= 66; c++) begin
      @(negedge clock);
      ini1 = 1'b0;
      kk = c / 4;
      e = model(1, 1, 15, c, -1, (kk > 15) ? 4'd0 : mem1[kk]);
      chk("r15.leds", c, 32'(leds1), 32'(e.leds));
      chk("r15.pronto", c, 32'(pr1), 32'(e.pr));
      chk("r15.endereco", c, 32'(end1), 32'(e.ende));
      chk("r15.ocupado", c, 32'(oc1), 32'(e.oc));
      lit += int'(est1 == 4'd2);
      np += int'(pr1);
    end
    chk("r15.lit_cycles", 66, 32'(lit), 32'd16);
    chk("r15.pronto_count", 66, 32'(np), 32'd1);
    chk("r15.dut0_idle", 66, 32'(oc0), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mostra_sequencia.md
Name: mostra_sequencia

Overview:
Sequence presenter for the memory game. It is the transmitter side of the LED/button exchange: for the current round it reads memory positions 0..rodada and flashes each stored value on the LEDs. Each value is lit for a fixed on-time and followed by a fixed dark gap. When the last value has been shown it signals completion, so the game controller can move to its wait-for-player states.

Parameters:
T_ACESO, 500, clock cycles each value stays lit on leds (>=1)
T_APAGADO, 250, clock cycles of dark gap after each value (>=1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; 0 forces idle
iniciar  input  1  start request, sampled only in OCIOSO
abortar  input  1  synchronous abort, returns to OCIOSO without pronto
rodada  input  4  index of the last memory position to show (0..15)
dado  input  4  memory read data; synchronous ROM, valid the cycle after endereco is presented
endereco  output  4  memory address being shown
leds  output  4  LED drive; dado while lit, 0 otherwise
ocupado  output  1  high in every state except OCIOSO
pronto  output  1  one-cycle pulse when the sequence is complete
db_estado  output  4  state code for the 7-seg debug display
db_indice  output  4  current index, equal to endereco

Behaviour:
- Reset (reset=0, async) forces:
  - state OCIOSO, index 0, timer 0, latched round 0
  - endereco=0, leds=0, ocupado=0, pronto=0, db_estado=0
  - reset mid-sequence blanks leds immediately, with no pronto.
- State codes: OCIOSO=0, ENDERECA=1, ACESO=2, APAGADO=3, PROXIMO=4, FIM=5. Unused codes return to OCIOSO.
- OCIOSO: when iniciar=1 at an edge, latch rodada into rodada_reg, set index=0, go to ENDERECA. Otherwise stay.
- ENDERECA (1 cycle): endereco=index, so the memory samples the address at the exit edge. Clear the timer and go to ACESO.
- ACESO (T_ACESO cycles): leds=dado, endereco held. Timer counts up. When timer=T_ACESO-1, clear the timer and go to APAGADO.
- APAGADO (T_APAGADO cycles): leds=0. When timer=T_APAGADO-1, clear the timer and go to PROXIMO.
- PROXIMO (1 cycle): if index=rodada_reg, go to FIM. Otherwise increment index and go to ENDERECA.
- FIM (1 cycle): pronto=1, then go to OCIOSO. ocupado is still 1 during FIM.
- Timing per element is exactly T_ACESO+T_APAGADO+2 cycles. Number the cycle after the start edge as c0:
  - lights on for index k during c(k·P+1) .. c(k·P+T_ACESO), where P is the per-element period
  - pronto at c((rodada+1)·P)
- leds is combinational from the state and dado. It is never nonzero outside ACESO.
- The timer is sized to max(T_ACESO,T_APAGADO)-1 and is reset on every state entry.
- rodada is sampled only at start; changes while busy are ignored.
- rodada=15 shows 16 values. index never wraps, because the PROXIMO compare happens before any increment.
- iniciar while ocupado=1 is ignored (no restart, no queueing).
- abortar=1 in any non-OCIOSO state: next state OCIOSO, index 0, leds 0 from the next cycle, no pronto.
  - abortar has priority over all timer transitions.
  - abortar together with iniciar in OCIOSO: abortar wins and the block stays idle.

Test Plan:
Parameters T_ACESO=3, T_APAGADO=2 (P=7); memory contents addr0=1, addr1=2, addr2=4, addr3=8.
1. Reset while ocupado=1 and leds=2 -> leds=0, ocupado=0, db_estado=0 immediately; a later iniciar works normally.
2. rodada=0, iniciar pulse -> leds=1 during c1..c3 and 0 at c4..c6; pronto=1 only at c7; ocupado=1 during c0..c7; endereco=0 throughout.
3. rodada=2 -> leds sequence 1,2,4 at c1–c3, c8–c10, c15–c17; pronto at c21; endereco steps 0→1→2 at ENDERECA entries.
4. rodada=2, rodada changed to 0 at c5, iniciar re-pulsed at c9 -> behaviour identical to scenario 3 and a single pronto at c21.
5. rodada=3, abortar=1 at c9 -> leds=0 from c10; state OCIOSO; no pronto; next iniciar restarts at index 0.
6. rodada=15 with T_ACESO=1, T_APAGADO=1 (P=4) -> 16 lit cycles with endereco 0..15 in order; pronto at c64; index never exceeds 15.
